// File: rtl/kv_response_builder.sv
// Packs a KV response descriptor plus optional value stream into one AXI-Stream packet.
// Beat 0 carries the 128-bit header; value words are shifted up by 128 bits across beats.
module kv_response_builder #(
  parameter int DATA_WIDTH = 512,
  parameter int META_WIDTH = 96
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [META_WIDTH-1:0]   s_meta_data,
  input  logic                    s_meta_valid,
  output logic                    s_meta_ready,
  input  logic [DATA_WIDTH-1:0]   s_value_data,
  input  logic                    s_value_valid,
  output logic                    s_value_ready,
  input  logic                    s_value_last,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    err_len,
  output logic [31:0]             pkt_count
);

  localparam int KEEP_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, FIRST, BODY, FLUSH} state_t;

  state_t        state_reg, state_next;
  logic [15:0]   words_left_reg, words_left_next;
  logic [127:0]  hdr_reg, hdr_next;
  logic [127:0]  carry_reg, carry_next;

  logic                  out_free, meta_fire, value_fire;
  logic                  load, last_next;
  logic [6:0]            keep_bytes;
  logic [DATA_WIDTH-1:0] data_raw, data_masked;
  logic [KEEP_W-1:0]     keep_next;
  logic [127:0]          meta_hdr;
  logic [15:0]           meta_vallen;
  logic [3:0]            take_words;
  logic [15:0]           rem_words;
  logic                  last_in, need_flush;

  assign out_free      = !m_axis_tvalid || m_axis_tready;
  assign s_meta_ready  = !rst && (state_reg == IDLE) && out_free;
  assign s_value_ready = !rst && ((state_reg == FIRST) || (state_reg == BODY)) && out_free;
  assign meta_fire     = s_meta_valid && s_meta_ready;
  assign value_fire    = s_value_valid && s_value_ready;

  assign meta_vallen = s_meta_data[79:64];
  assign meta_hdr    = {s_meta_data[63:0], s_meta_data[95:88] | 8'h80, s_meta_data[87:80],
                        s_meta_data[79:64], 16'h0000, 16'hFFFF};

  // A value beat carries at most 8 words; 6 fit behind the 16-byte header/carry slot.
  assign take_words = (words_left_reg >= 16'd8) ? 4'd8 : words_left_reg[3:0];
  assign rem_words  = words_left_reg - {12'd0, take_words};
  assign last_in    = (words_left_reg <= 16'd8);
  assign need_flush = last_in && (take_words >= 4'd7);

  always_comb begin
    state_next      = state_reg;
    words_left_next = words_left_reg;
    hdr_next        = hdr_reg;
    carry_next      = carry_reg;
    load            = 1'b0;
    last_next       = 1'b0;
    keep_bytes      = 7'd64;
    data_raw        = '0;
    case (state_reg)
      IDLE: begin
        if (meta_fire) begin
          hdr_next        = meta_hdr;
          words_left_next = meta_vallen;
          if (meta_vallen == 16'd0) begin
            load       = 1'b1;
            data_raw   = {384'b0, meta_hdr};
            keep_bytes = 7'd16;
            last_next  = 1'b1;
          end else begin
            state_next = FIRST;
          end
        end
      end
      FIRST, BODY: begin
        if (value_fire) begin
          load            = 1'b1;
          data_raw        = {s_value_data[383:0], (state_reg == FIRST) ? hdr_reg : carry_reg};
          carry_next      = s_value_data[511:384];
          words_left_next = rem_words;
          if (!last_in) begin
            state_next = BODY;
          end else if (need_flush) begin
            state_next = FLUSH;
          end else begin
            state_next = IDLE;
            last_next  = 1'b1;
            keep_bytes = 7'd16 + {take_words, 3'b000};
          end
        end
      end
      FLUSH: begin
        if (out_free) begin
          load       = 1'b1;
          data_raw   = {384'b0, carry_reg};
          last_next  = 1'b1;
          // Carry holds one leftover word when V mod 8 == 7, two when V mod 8 == 0.
          keep_bytes = (hdr_reg[34:32] == 3'd7) ? 7'd8 : 7'd16;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  generate
    for (genvar gi = 0; gi < KEEP_W; gi++) begin : g_keep
      assign keep_next[gi]          = (7'(gi) < keep_bytes);
      assign data_masked[gi*8 +: 8] = data_raw[gi*8 +: 8] & {8{keep_next[gi]}};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      words_left_reg <= '0;
      hdr_reg        <= '0;
      carry_reg      <= '0;
      m_axis_tdata   <= '0;
      m_axis_tkeep   <= '0;
      m_axis_tvalid  <= 1'b0;
      m_axis_tlast   <= 1'b0;
      err_len        <= 1'b0;
      pkt_count      <= '0;
    end else begin
      state_reg      <= state_next;
      words_left_reg <= words_left_next;
      hdr_reg        <= hdr_next;
      carry_reg      <= carry_next;
      if (load) begin
        m_axis_tdata  <= data_masked;
        m_axis_tkeep  <= keep_next;
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= last_next;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (value_fire && (s_value_last != last_in)) begin
        err_len <= 1'b1;
      end
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
        pkt_count <= pkt_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_kv_response_builder.sv
// Directed bench for kv_response_builder: header layout, realignment, flush beats,
// final tkeep, stall stability, err_len and mid-packet reset.
module tb_kv_response_builder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [95:0]  s_meta_data = '0;
  logic         s_meta_valid = 1'b0;
  logic         s_meta_ready;
  logic [511:0] s_value_data = '0;
  logic         s_value_valid = 1'b0;
  logic         s_value_ready;
  logic         s_value_last = 1'b0;
  logic [511:0] m_axis_tdata;
  logic [63:0]  m_axis_tkeep;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b1;
  logic         m_axis_tlast;
  logic         err_len;
  logic [31:0]  pkt_count;

  kv_response_builder dut (
    .clk(clk), .rst(rst),
    .s_meta_data(s_meta_data), .s_meta_valid(s_meta_valid), .s_meta_ready(s_meta_ready),
    .s_value_data(s_value_data), .s_value_valid(s_value_valid), .s_value_ready(s_value_ready),
    .s_value_last(s_value_last),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .err_len(err_len), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] d;
    logic [63:0]  k;
    logic         l;
  } beat_t;

  beat_t bq[$];
  beat_t got[8];
  int    tests = 0;
  int    fails = 0;
  logic  toggle_en = 1'b0;

  task automatic chk(string tag, logic [511:0] obs, logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // tready is either held high or toggled every cycle.
  always @(posedge clk) begin
    #1;
    m_axis_tready = toggle_en ? ~m_axis_tready : 1'b1;
  end

  logic         prev_stall = 1'b0, prev_rst = 1'b1, prev_l = 1'b0;
  logic [511:0] prev_d = '0;
  logic [63:0]  prev_k = '0;

  always @(negedge clk) begin
    if (!rst && m_axis_tvalid && m_axis_tready)
      bq.push_back('{d: m_axis_tdata, k: m_axis_tkeep, l: m_axis_tlast});
    if (!rst && !prev_rst && prev_stall) begin
      chk("stall_data", m_axis_tdata, prev_d);
      chk("stall_keep", m_axis_tkeep, prev_k);
      chk("stall_last", m_axis_tlast, prev_l);
    end
    if (!rst && m_axis_tvalid && !m_axis_tready) begin
      chk("stall_value_ready", s_value_ready, 1'b0);
      chk("stall_meta_ready", s_meta_ready, 1'b0);
    end
    prev_stall <= m_axis_tvalid && !m_axis_tready;
    prev_rst   <= rst;
    prev_d     <= m_axis_tdata;
    prev_k     <= m_axis_tkeep;
    prev_l     <= m_axis_tlast;
  end

  function automatic logic [63:0] word(int k);
    return 64'hA5A5_0000_0000_0000 + 64'(k);
  endfunction

  function automatic logic [127:0] hdr(logic [7:0] op, logic [7:0] st, logic [15:0] v,
                                       logic [63:0] net);
    return {net, op | 8'h80, st, v, 16'h0000, 16'hFFFF};
  endfunction

  // Input value beat b of a V-word value; unused slots hold junk that must never appear.
  function automatic logic [511:0] vbeat(int b, int v);
    logic [511:0] r;
    for (int i = 0; i < 8; i++)
      r[64*i +: 64] = (8*b + i + 1 <= v) ? word(8*b + i + 1) : 64'hDEAD_BEEF_DEAD_BEEF;
    return r;
  endfunction

  task automatic send_meta(logic [7:0] op, logic [7:0] st, logic [15:0] v, logic [63:0] net);
    int n = 0;
    s_meta_data  = {op, st, v, net};
    s_meta_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_meta_ready) break;
      n++;
      if (n > 100) begin
        tests++; fails++;
        $display("FAIL meta_timeout: s_meta_ready never rose within 100 cycles");
        break;
      end
    end
    @(posedge clk); #1;
    s_meta_valid = 1'b0;
  endtask

  task automatic send_value(logic [511:0] d, logic last);
    int n = 0;
    s_value_data  = d;
    s_value_last  = last;
    s_value_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_value_ready) break;
      n++;
      if (n > 100) begin
        tests++; fails++;
        $display("FAIL value_timeout: s_value_ready never rose within 100 cycles");
        break;
      end
    end
    @(posedge clk); #1;
    s_value_valid = 1'b0;
    s_value_last  = 1'b0;
  endtask

  // Expected packet: header (2 words) then V value words, 8 words per beat, zero-padded.
  task automatic expect_pkt(string tag, logic [127:0] h, int v);
    int nb = (v + 2 + 7) / 8;
    int n = 0;
    int g, bytes;
    beat_t b;
    logic [511:0] ed;
    logic [63:0]  ek;
    while (bq.size() < nb && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (bq.size() < nb) begin
      tests++; fails++;
      $display("FAIL %s_timeout: observed %0d beats required %0d", tag, bq.size(), nb);
      return;
    end
    for (int j = 0; j < nb; j++) begin
      b = bq.pop_front();
      got[j] = b;
      for (int i = 0; i < 8; i++) begin
        g = 8*j + i;
        ed[64*i +: 64] = (g == 0) ? h[63:0] : (g == 1) ? h[127:64] :
                         (g <= v + 1) ? word(g - 1) : 64'h0;
      end
      bytes = 8 * ((v + 2) - 8*(nb - 1));
      ek = (j < nb - 1 || bytes == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'h1 << bytes) - 64'h1);
      chk($sformatf("%s_b%0d_data", tag, j), b.d, ed);
      chk($sformatf("%s_b%0d_keep", tag, j), b.k, ek);
      chk($sformatf("%s_b%0d_last", tag, j), b.l, (j == nb - 1));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] h;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_tlast", m_axis_tlast, 1'b0);
    chk("rst_tkeep", m_axis_tkeep, 64'h0);
    chk("rst_tdata", m_axis_tdata, 512'h0);
    chk("rst_meta_ready", s_meta_ready, 1'b0);
    chk("rst_value_ready", s_value_ready, 1'b0);
    chk("rst_err_len", err_len, 1'b0);
    chk("rst_pkt_count", pkt_count, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // V=0 header-only packet, one-cycle latency
    h = hdr(8'h01, 8'h00, 16'd0, 64'hA5);
    send_meta(8'h01, 8'h00, 16'd0, 64'hA5);
    chk("v0_latency_tvalid", m_axis_tvalid, 1'b1);
    expect_pkt("v0", h, 0);
    chk("v0_opcode", got[0].d[63:56], 8'h81);
    chk("v0_vallen", got[0].d[47:32], 16'h0000);
    chk("v0_magic", got[0].d[15:0], 16'hFFFF);
    chk("v0_netmeta", got[0].d[127:64], 64'hA5);
    chk("v0_keep", got[0].k, 64'h0000_0000_0000_FFFF);
    chk("v0_pkt_count", pkt_count, 32'd1);

    // Back-to-back V=0 packets
    send_meta(8'h05, 8'h01, 16'd0, 64'h1111);
    send_meta(8'h06, 8'h02, 16'd0, 64'h2222);
    expect_pkt("b2b_a", hdr(8'h05, 8'h01, 16'd0, 64'h1111), 0);
    expect_pkt("b2b_b", hdr(8'h06, 8'h02, 16'd0, 64'h2222), 0);
    chk("b2b_pkt_count", pkt_count, 32'd3);

    // V=6: one beat, all bytes valid
    send_meta(8'h02, 8'h00, 16'd6, 64'hBEEF);
    send_value(vbeat(0, 6), 1'b1);
    chk("v6_latency_tvalid", m_axis_tvalid, 1'b1);
    expect_pkt("v6", hdr(8'h02, 8'h00, 16'd6, 64'hBEEF), 6);
    chk("v6_word1", got[0].d[191:128], word(1));
    chk("v6_word6", got[0].d[511:448], word(6));
    chk("v6_keep", got[0].k, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("v6_last", got[0].l, 1'b1);

    // V=7: flush beat with a single word
    send_meta(8'h02, 8'h00, 16'd7, 64'h7);
    send_value(vbeat(0, 7), 1'b1);
    expect_pkt("v7", hdr(8'h02, 8'h00, 16'd7, 64'h7), 7);
    chk("v7_word7", got[1].d[63:0], word(7));
    chk("v7_upper_zero", got[1].d[511:64], 448'h0);
    chk("v7_keep", got[1].k, 64'hFF);
    chk("v7_err_len", err_len, 1'b0);

    // V=16: two input beats, flush of two words
    send_meta(8'h03, 8'h00, 16'd16, 64'h16);
    send_value(vbeat(0, 16), 1'b0);
    send_value(vbeat(1, 16), 1'b1);
    expect_pkt("v16", hdr(8'h03, 8'h00, 16'd16, 64'h16), 16);
    chk("v16_keep", got[2].k, 64'hFFFF);
    chk("v16_word16", got[2].d[127:64], word(16));
    chk("v16_err_len", err_len, 1'b0);

    // V=14 with tready toggling
    toggle_en = 1'b1;
    send_meta(8'h04, 8'h00, 16'd14, 64'h14);
    send_value(vbeat(0, 14), 1'b0);
    send_value(vbeat(1, 14), 1'b1);
    expect_pkt("v14", hdr(8'h04, 8'h00, 16'd14, 64'h14), 14);
    toggle_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("v14_pkt_count", pkt_count, 32'd7);

    // V=20 with early s_value_last
    send_meta(8'h02, 8'h03, 16'd20, 64'h20);
    send_value(vbeat(0, 20), 1'b0);
    send_value(vbeat(1, 20), 1'b1);
    chk("v20_err_set", err_len, 1'b1);
    send_value(vbeat(2, 20), 1'b0);
    expect_pkt("v20", hdr(8'h02, 8'h03, 16'd20, 64'h20), 20);
    chk("v20_final_keep", got[2].k, 64'h0000_FFFF_FFFF_FFFF);
    chk("v20_err_sticky", err_len, 1'b1);

    // Reset mid-packet
    send_meta(8'h02, 8'h00, 16'd10, 64'h10);
    send_value(vbeat(0, 10), 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_tvalid", m_axis_tvalid, 1'b0);
    chk("midrst_tdata", m_axis_tdata, 512'h0);
    chk("midrst_tkeep", m_axis_tkeep, 64'h0);
    chk("midrst_tlast", m_axis_tlast, 1'b0);
    chk("midrst_err_len", err_len, 1'b0);
    chk("midrst_pkt_count", pkt_count, 32'd0);
    chk("midrst_meta_ready", s_meta_ready, 1'b0);
    chk("midrst_value_ready", s_value_ready, 1'b0);
    rst = 1'b0;
    bq.delete();
    @(posedge clk); #1;
    send_meta(8'h09, 8'h01, 16'd0, 64'hCAFE);
    expect_pkt("post_rst", hdr(8'h09, 8'h01, 16'd0, 64'hCAFE), 0);
    chk("post_rst_pkt_count", pkt_count, 32'd1);
    chk("post_rst_err_len", err_len, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
